// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: reset PC, NOP word,
// opcode field bounds, fetch state encoding and the buffered fetch payload.
package fetch_stage_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } fetch_word_t;

  // Sequential PC advance; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble (pc4 kept), load
// captures a fetched word as valid, otherwise contents are held.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            flush_i,
  input  fetch_word_t     word_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = word_i.instr;
      pc4_d   = word_i.pc4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one-word skid buffer for stalled acks,
// FETCH/HOLD control and the IF/ID register feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [XLEN-1:0]     imem_rdata,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [XLEN-1:0]     branch_target,
  output logic [XLEN-1:0]     if_id_instr,
  output logic [XLEN-1:0]     if_id_pc4,
  output logic                if_id_valid,
  output logic [OPCODE_W-1:0] opcode
);

  fetch_state_e    state_q;
  logic            req_q;
  logic [XLEN-1:0] pc_q;
  fetch_word_t     buf_q;

  logic            load_c;
  logic            flush_c;
  fetch_word_t     word_c;
  logic [XLEN-1:0] pc4_c;
  logic [1:0]      tgt_lsb_unused;

  assign pc4_c          = pc_plus4(pc_q);
  assign tgt_lsb_unused = branch_target[1:0];

  // IF/ID control; a redirect squashes whatever else happens this cycle.
  always_comb begin
    load_c  = 1'b0;
    flush_c = 1'b0;
    word_c  = '{instr: imem_rdata, pc4: pc4_c};
    if (branch_taken) begin
      flush_c = 1'b1;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (imem_ack && !stall) begin
            load_c = 1'b1;
          end else if (!imem_ack && !stall) begin
            flush_c = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            load_c = 1'b1;
            word_c = buf_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      req_q   <= 1'b1;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else if (branch_taken) begin
      state_q <= ST_FETCH;
      req_q   <= 1'b1;
      pc_q    <= {branch_target[XLEN-1:2], 2'b00};
      buf_q   <= '0;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (imem_ack) begin
            pc_q <= pc4_c;
            if (stall) begin
              buf_q   <= '{instr: imem_rdata, pc4: pc4_c};
              state_q <= ST_HOLD;
              req_q   <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_c),
    .flush_i (flush_c),
    .word_i  (word_c),
    .instr_o (if_id_instr),
    .pc4_o   (if_id_pc4),
    .valid_o (if_id_valid)
  );

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign opcode    = if_id_instr[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random traffic,
// checked against a queue-based fetch-stream reference model.
module tb_fetch_stage;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(TB_RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .opcode        (opcode)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } word_t;

  exp_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;

  // Reference model: PC, words fetched but not yet delivered, and IF/ID view.
  logic [31:0] m_pc;
  word_t       pending[$];
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    check("imem_req",    {31'b0, imem_req},    {31'b0, e.req});
    check("imem_addr",   imem_addr,            e.addr);
    check("if_id_instr", if_id_instr,          e.instr);
    check("if_id_pc4",   if_id_pc4,            e.pc4);
    check("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
    check("opcode",      {26'b0, opcode},      {26'b0, e.instr[31:26]});
  endtask

  // Monitor: one expected snapshot per settled cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check_all(exp_q.pop_front());
  end

  function automatic exp_t model_view();
    exp_t e;
    e.req   = (pending.size() == 0);
    e.addr  = m_pc;
    e.instr = m_instr;
    e.pc4   = m_pc4;
    e.valid = m_valid;
    return e;
  endfunction

  task automatic model_reset();
    m_pc    = TB_RESET_PC;
    pending.delete();
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic model_step(input logic a, input logic s, input logic b,
                            input logic [31:0] tgt, input logic [31:0] data);
    word_t w;
    if (b) begin
      m_pc    = tgt & 32'hFFFF_FFFC;
      pending.delete();
      m_instr = 32'h0;
      m_valid = 1'b0;
    end else if (pending.size() > 0) begin
      if (!s) begin
        w       = pending.pop_front();
        m_instr = w.instr;
        m_pc4   = w.pc4;
        m_valid = 1'b1;
      end
    end else if (a) begin
      w.instr = data;
      w.pc4   = m_pc + 32'd4;
      m_pc    = w.pc4;
      if (s) pending.push_back(w);
      else begin
        m_instr = w.instr;
        m_pc4   = w.pc4;
        m_valid = 1'b1;
      end
    end else if (!s) begin
      m_instr = 32'h0;
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle of inputs just after negedge and queue the expected result.
  task automatic cycle(input logic a, input logic s, input logic b,
                       input logic [31:0] tgt, input logic [31:0] data);
    imem_ack      = a;
    stall         = s;
    branch_taken  = b;
    branch_target = tgt;
    imem_rdata    = data;
    model_step(a, s, b, tgt, data);
    exp_q.push_back(model_view());
    @(negedge clk);
    #1;
  endtask

  initial begin
    exp_t rst_e;
    rst_e = '{req: 1'b1, addr: TB_RESET_PC, instr: 32'h0, pc4: 32'h0, valid: 1'b0};

    rst = 1'b1;
    imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    model_reset();
    @(negedge clk); #1;
    exp_q.push_back(rst_e);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;  // ack during reset is ignored
    @(negedge clk); #1;
    imem_ack = 1'b0;
    rst = 1'b0;

    // First word straight after reset, then the stalled ack at pc=8.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h2008_0005);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h8C41_0004);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h1022_0008);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, $urandom);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, $urandom);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, $urandom);
    // Redirect with a same-cycle ack, then two withheld acks.
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0043, 32'hAC22_0010);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, $urandom);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, $urandom);
    // PC wrap at the top of the address space.
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, $urandom);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h3C01_1234);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0800_0000);
    // Redirect while holding a buffered word discards it.
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h2408_0001);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0100, $urandom);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h2409_0002);

    // Asynchronous reset while in HOLD: outputs clear without a clock edge.
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h1111_2222);
    #2;
    rst = 1'b1;
    #1;
    check_all(rst_e);
    imem_ack = 1'b0; stall = 1'b0;
    model_reset();
    @(negedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 800; i++) begin
      logic a, s, b;
      s = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 15) == 0);
      a = (pending.size() == 0) && ($urandom_range(0, 3) != 0);
      cycle(a, s, b, $urandom, $urandom);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    if (exp_q.size() != 0) check("exp_q_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
